rr_grant8: RTL

- Round-robin arbiter for eight requesters.
- Produces a registered one-hot 8-bit grant vector plus an enable qualifier, feeding the downstream 8-to-3 one-hot encoder (grant -> ip, gnt_valid -> en).
- Guarantees the grant bus is always all-zero or exactly one-hot, so the encoder never sees an unlisted code.

---
 rtl/rr_grant8_if.sv | 11 +
 rtl/rr_grant8.sv | 66 ++++++
 2 files changed

// File: rtl/rr_grant8_if.sv
// rr_grant8_if: request/grant bundle between the requesters (master) and the round-robin arbiter (slave).
interface rr_grant8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout;
  modport master (output req, done, input gnt, gnt_valid, gnt_id, timeout);
  modport slave  (input req, done, output gnt, gnt_valid, gnt_id, timeout);
endinterface

// File: rtl/rr_grant8.sv
// rr_grant8: 8-way round-robin arbiter with registered one-hot grant and no-bubble handover.
// Define RR_GRANT8_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module rr_grant8 #(
  parameter int MAX_HOLD = 16
) (
  input logic      clk,
  input logic      rst_n,
  rr_grant8_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state, state_n;
  logic [2:0] ptr, ptr_n, id_n;
  logic [7:0] gnt_n, cand;
  logic       rel, frc, ng;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be within 1..255");
  end
  // First set bit of r scanning p, p+1, ... p+7 (mod 8).
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [15:0] d;
    d = {r, r} >> p;
    pick = p;
    for (int i = 7; i >= 0; i--) if (d[i]) pick = p + 3'(i);
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      bus.gnt    <= 8'h00;
      bus.gnt_id <= 3'd0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      bus.gnt    <= gnt_n;
      bus.gnt_id <= id_n;
    end
  // A timed-out owner is excluded from the re-arbitration at its own release edge.
  always_comb begin
    rel     = state == GRANT && (bus.done || !bus.req[bus.gnt_id] || frc);
    cand    = frc ? bus.req & ~(8'b1 << bus.gnt_id) : bus.req;
    ptr_n   = rel ? bus.gnt_id + 3'd1 : ptr;
    ng      = (state == IDLE && |bus.req) || (rel && |cand);
    state_n = state == IDLE ? (|bus.req ? GRANT : IDLE) : (rel && !(|cand)) ? IDLE : GRANT;
    id_n    = ng ? pick(cand, ptr_n) : bus.gnt_id;
  end
  always_comb begin
    gnt_n         = state_n == GRANT ? 8'b1 << id_n : 8'h00;
    bus.gnt_valid = |bus.gnt;
  end
`ifdef RR_GRANT8_TIMEOUT_EN
  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt;
  assign frc = state == GRANT && cnt == LAST && !bus.done && bus.req[bus.gnt_id];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt         <= 8'd0;
      bus.timeout <= 1'b0;
    end else begin
      cnt         <= ng ? 8'd0 : (state == GRANT && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
      bus.timeout <= frc;
    end
`else
  assign frc         = 1'b0;
  assign bus.timeout = 1'b0;
`endif
endmodule
